// File: rtl/seq_pkg.sv
// Shared state encoding and widths for the seq_ctrl sequencer and its PC unit.
package seq_pkg;

    localparam int unsigned PC_W_DEFAULT = 10;
    localparam int unsigned OFF_W        = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: clear, hold, or step to PC+1 / PC+sign_extend(offset), modulo 2^PC_W.
module pc_unit
    import seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic             take_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [PC_W-1:0]  pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] off_ext;

    // Narrow PCs keep only the low offset bits; the sum is the same modulo 2^PC_W.
    generate
        if (PC_W > OFF_W) begin : g_sext
            assign off_ext = {{(PC_W - OFF_W){off_i[OFF_W-1]}}, off_i};
        end else begin : g_trunc
            assign off_ext = off_i[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (step_i) begin
            pc_d = take_i ? (pc_q + off_ext) : (pc_q + PC_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer with Start/Ack handshake and gated decoder strobes.
// Define SEQ_CTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEFAULT,
    parameter int unsigned PROG_LEN = 1024
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             branch_on,
    input  logic             branch_cond,
    input  logic [OFF_W-1:0] imm,
    input  logic             write_reg,
    input  logic             write_mem,
    input  logic             read_mem,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  PC,
    output logic             ir_load,
    output logic             reg_we,
    output logic             mem_we,
    output logic             mem_re,
    output logic             mem_req,
    output logic             busy,
    output logic             Ack
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]      cycle_cnt,
    output logic [15:0]      instr_cnt
`endif
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    state_t state_q;
    state_t state_d;
    logic   pc_clr;
    logic   pc_step;

    pc_unit #(
        .PC_W(PC_W)
    ) u_pc (
        .clk_i (CLK),
        .rst_ni(Reset),
        .clr_i (pc_clr),
        .step_i(pc_step),
        .take_i(branch_on & branch_cond),
        .off_i (imm),
        .pc_o  (PC)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_clr  = 1'b0;
        pc_step = 1'b0;
        ir_load = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        mem_req = 1'b0;
        busy    = 1'b0;
        Ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_clr = 1'b1;
                if (Start) state_d = FETCH;
            end
            FETCH: begin
                ir_load = 1'b1;
                busy    = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                state_d = (read_mem | write_mem) ? MEM : WB;
            end
            MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_re  = read_mem;
                mem_we  = write_mem;
                if (mem_ack) state_d = WB;
            end
            WB: begin
                busy    = 1'b1;
                reg_we  = write_reg;
                pc_step = 1'b1;
                state_d = (PC == LAST_PC) ? DONE : FETCH;
            end
            DONE: begin
                Ack = 1'b1;
                if (!Start) begin
                    pc_clr  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                pc_clr  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

`ifdef SEQ_CTRL_PERF_EN
    logic [15:0] cyc_q;
    logic [15:0] ins_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else if (state_q == IDLE && Start) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (busy && cyc_q != '1) cyc_q <= cyc_q + 16'd1;
            if (state_q == WB && ins_q != '1) ins_q <= ins_q + 16'd1;
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;
`else
    // Counters absent: sequencing is unaffected.
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Randomized self-checking bench for seq_ctrl against an instruction-level reference model.
module tb_seq_ctrl;

    localparam int PCW  = 4;
    localparam int PLEN = 12;
    localparam int LAST = PLEN - 1;
    localparam int NPC  = 1 << PCW;

    logic           CLK = 1'b0;
    logic           Reset = 1'b0;
    logic           Start = 1'b0;
    logic           branch_on = 1'b0;
    logic           branch_cond = 1'b0;
    logic [4:0]     imm = '0;
    logic           write_reg = 1'b0;
    logic           write_mem = 1'b0;
    logic           read_mem = 1'b0;
    logic           mem_ack = 1'b0;
    logic [PCW-1:0] PC;
    logic           ir_load, reg_we, mem_we, mem_re, mem_req, busy, Ack;
`ifdef SEQ_CTRL_PERF_EN
    logic [15:0]    cycle_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Program image: one decoded instruction per ROM address.
    bit         p_br[NPC];
    bit         p_cond[NPC];
    logic [4:0] p_imm[NPC];
    bit         p_wr[NPC];
    bit         p_wm[NPC];
    bit         p_rm[NPC];
    int         p_dly[NPC];

    logic [10:0] obs;
    assign obs = {PC, ir_load, reg_we, mem_we, mem_re, mem_req, busy, Ack};

    seq_ctrl #(
        .PC_W    (PCW),
        .PROG_LEN(PLEN)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .branch_on  (branch_on),
        .branch_cond(branch_cond),
        .imm        (imm),
        .write_reg  (write_reg),
        .write_mem  (write_mem),
        .read_mem   (read_mem),
        .mem_ack    (mem_ack),
        .PC         (PC),
        .ir_load    (ir_load),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_req    (mem_req),
        .busy       (busy),
        .Ack        (Ack)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected output vector {PC, ir_load, reg_we, mem_we, mem_re, mem_req, busy, Ack}.
    function automatic logic [10:0] ev(input int pc, input bit irl, input bit rwe, input bit mwe,
                                       input bit mre, input bit mrq, input bit bsy, input bit ack);
        return {4'(pc), irl, rwe, mwe, mre, mrq, bsy, ack};
    endfunction

    function automatic int sext5(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    // Called at posedge+1: check outputs at the falling edge, then return at the next posedge+1.
    task automatic cyc(input string tag, input logic [10:0] want);
        @(negedge CLK);
        check_eq(tag, 32'(obs), 32'(want));
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_instr(input int pc);
        branch_on   = p_br[pc];
        branch_cond = p_cond[pc];
        imm         = p_imm[pc];
        write_reg   = p_wr[pc];
        write_mem   = p_wm[pc];
        read_mem    = p_rm[pc];
    endtask

    task automatic clear_prog();
        for (int a = 0; a < NPC; a++) begin
            p_br[a]  = 1'b0;
            p_cond[a] = 1'b0;
            p_imm[a] = '0;
            p_wr[a]  = 1'b1;
            p_wm[a]  = 1'b0;
            p_rm[a]  = 1'b0;
            p_dly[a] = 0;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        check_eq("reset_outs", 32'(obs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef SEQ_CTRL_PERF_EN
        check_eq("reset_cyc_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("reset_ins_cnt", 32'(instr_cnt), 32'd0);
`endif
        Start = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    // Walk the program instruction by instruction from PC 0; stop by reset after cap instructions.
    task automatic run_prog(input int cap);
        int pc = 0;
        int n = 0;
        int cycles = 0;
        int off;
        int hold;
        bit finished = 1'b0;
        Start = 1'b1;
        mem_ack = 1'b0;
        cyc("idle", ev(0, 0, 0, 0, 0, 0, 0, 0));
        while (!finished && n < cap) begin
            drive_instr(pc);
            mem_ack = 1'($urandom_range(0, 1));
            Start   = 1'($urandom_range(0, 1));
            cyc("fetch", ev(pc, 1, 0, 0, 0, 0, 1, 0));
            cycles++;
            mem_ack = 1'($urandom_range(0, 1));
            cyc("exec", ev(pc, 0, 0, 0, 0, 0, 1, 0));
            cycles++;
            if (p_rm[pc] || p_wm[pc]) begin
                for (int k = 0; k <= p_dly[pc]; k++) begin
                    mem_ack = (k == p_dly[pc]);
                    cyc("mem", ev(pc, 0, 0, p_wm[pc], p_rm[pc], 1, 1, 0));
                    cycles++;
                end
            end
            mem_ack = 1'($urandom_range(0, 1));
            cyc("wb", ev(pc, 0, p_wr[pc], 0, 0, 0, 1, 0));
            cycles++;
            n++;
            if (pc == LAST) finished = 1'b1;
            off = (p_br[pc] && p_cond[pc]) ? sext5(p_imm[pc]) : 1;
            pc  = ((pc + off) % NPC + NPC) % NPC;
        end
        mem_ack = 1'b0;
        if (finished) begin
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                Start = 1'b1;
                cyc("done_hold", ev(pc, 0, 0, 0, 0, 0, 0, 1));
            end
            Start = 1'b0;
            cyc("done_exit", ev(pc, 0, 0, 0, 0, 0, 0, 1));
`ifdef SEQ_CTRL_PERF_EN
            check_eq("cycle_cnt", 32'(cycle_cnt), 32'(cycles));
            check_eq("instr_cnt", 32'(instr_cnt), 32'(n));
`endif
            cyc("idle_back", ev(0, 0, 0, 0, 0, 0, 0, 0));
        end else begin
            do_reset();
        end
    endtask

    task automatic reset_in_mem();
        clear_prog();
        p_wr[0]  = 1'b0;
        p_wm[0]  = 1'b1;
        p_dly[0] = 5;
        Start = 1'b1;
        mem_ack = 1'b0;
        drive_instr(0);
        cyc("rm_idle", ev(0, 0, 0, 0, 0, 0, 0, 0));
        cyc("rm_fetch", ev(0, 1, 0, 0, 0, 0, 1, 0));
        cyc("rm_exec", ev(0, 0, 0, 0, 0, 0, 1, 0));
        cyc("rm_mem", ev(0, 0, 0, 1, 0, 1, 1, 0));
        #2;
        check_eq("rm_mem_pre", 32'(obs), 32'(ev(0, 0, 0, 1, 0, 1, 1, 0)));
        Reset = 1'b0;
        #1;
        check_eq("rm_reset_now", 32'(obs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 0)));
        @(posedge CLK);
        #1;
        check_eq("rm_reset_held", 32'(obs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 0)));
        Start = 1'b0;
        Reset = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        clear_prog();
        run_prog(40);

        clear_prog();
        p_rm[2]  = 1'b1;
        p_dly[2] = 2;
        run_prog(40);

        clear_prog();
        p_br[5]   = 1'b1;
        p_cond[5] = 1'b1;
        p_imm[5]  = 5'b11101;
        run_prog(12);

        p_cond[5] = 1'b0;
        run_prog(40);

        clear_prog();
        p_br[0]   = 1'b1;
        p_cond[0] = 1'b1;
        p_imm[0]  = 5'd14;
        p_br[14]  = 1'b1;
        p_cond[14] = 1'b1;
        p_imm[14] = 5'b00011;
        run_prog(40);

        clear_prog();
        p_br[0]   = 1'b1;
        p_cond[0] = 1'b1;
        p_imm[0]  = 5'd0;
        run_prog(5);

        clear_prog();
        p_br[0]   = 1'b1;
        p_cond[0] = 1'b1;
        p_imm[0]  = 5'd10;
        p_wr[11]  = 1'b0;
        p_wm[11]  = 1'b1;
        run_prog(40);

        reset_in_mem();

        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < NPC; a++) begin
                int kind;
                kind      = $urandom_range(0, 3);
                p_br[a]   = ($urandom_range(0, 3) == 0);
                p_cond[a] = 1'($urandom_range(0, 1));
                p_imm[a]  = 5'($urandom);
                p_wr[a]   = 1'($urandom_range(0, 1));
                p_wm[a]   = (kind == 2);
                p_rm[a]   = (kind == 3);
                p_dly[a]  = $urandom_range(0, 4);
            end
            run_prog(40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
